// File: rtl/io_input_fifo_if.sv
// Byte-source and core-side signals of the input staging FIFO.
// The slave modport belongs to the FIFO. The master modport belongs to whatever drives it.
interface io_input_fifo_if #(
    parameter int DEPTH = 8
);
    logic [7:0]             ext_data;
    logic                   ext_valid;
    logic                   ext_ready;
    logic [7:0]             cpu_data;
    logic                   cpu_irq;
    logic                   cpu_ack;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    modport slave (
        input  ext_data, ext_valid, cpu_ack,
        output ext_ready, cpu_data, cpu_irq, count, overflow
    );

    modport master (
        output ext_data, ext_valid, cpu_ack,
        input  ext_ready, cpu_data, cpu_irq, count, overflow
    );
endinterface

// File: rtl/io_input_fifo.sv
// First-word-fall-through byte FIFO that feeds the core's data_in bus.
// A request/acknowledge FSM drives the core interrupt and applies a holdoff after each acknowledge.
module io_input_fifo #(
    parameter int DEPTH         = 8,
    parameter int IRQ_THRESHOLD = 1,
    parameter int HOLDOFF       = 4
) (
    input  logic           clk,
    input  logic           reset,
    io_input_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    state_t        state, state_nxt;
    logic [3:0]    hold_cnt, hold_nxt;

    logic full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.ext_valid && !full;
    assign pop   = bus.cpu_ack && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.ext_valid && full) ovf_q <= 1'b1;
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // The storage array needs no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr] <= bus.ext_data;
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (count_q >= CW'(IRQ_THRESHOLD)) state_nxt = PEND;
            end
            PEND: begin
                if (pop) begin
                    state_nxt = HOLD;
                    hold_nxt  = 4'(HOLDOFF);
                end else if (count_q < CW'(IRQ_THRESHOLD)) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                // HOLD is entered with HOLDOFF loaded, so the state lasts exactly HOLDOFF cycles.
                if (hold_cnt <= 4'd1) begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    assign bus.ext_ready = !full;
    assign bus.cpu_data  = empty ? 8'h00 : mem[rd_ptr];
    assign bus.cpu_irq   = (state == PEND);
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_io_input_fifo.sv
// Runs directed and random traffic into io_input_fifo and checks every cycle against a queue-based model.
// Literal expectations for the directed tests pin down the model itself.
module tb_io_input_fifo;
    localparam int DEPTH = 8;
    localparam int THR   = 1;
    localparam int HOLD  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    io_input_fifo_if #(.DEPTH(DEPTH)) bus();

    io_input_fifo #(.DEPTH(DEPTH), .IRQ_THRESHOLD(THR), .HOLDOFF(HOLD)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int checks = 0;
    int passed = 0;

    byte unsigned mq[$];
    bit m_irq = 1'b0;
    bit m_ovf = 1'b0;
    int edge_n = 0;
    int ack_edge = -1000;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Interrupt rule used by the model:
    // - An acknowledge at edge a keeps cpu_irq low through the state after edge a+HOLD.
    // - After that window, the interrupt rises at the first edge whose previous cycle showed occupancy >= THR.
    task automatic model_update();
        int  n;
        bit  push, pop;
        n = mq.size();
        edge_n++;
        if (!reset) begin
            mq.delete();
            m_irq = 1'b0;
            m_ovf = 1'b0;
            ack_edge = -1000;
        end else begin
            push = bus.ext_valid && (n < DEPTH);
            pop  = bus.cpu_ack && (n > 0);
            if (bus.ext_valid && n == DEPTH) m_ovf = 1'b1;
            if (m_irq) begin
                if (pop) begin
                    m_irq = 1'b0;
                    ack_edge = edge_n;
                end else if (n < THR) begin
                    m_irq = 1'b0;
                end
            end else if ((edge_n - 1 >= ack_edge + HOLD) && n >= THR) begin
                m_irq = 1'b1;
            end
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(bus.ext_data);
        end
    endtask

    task automatic compare();
        chk("count",     int'(bus.count),     mq.size());
        chk("ext_ready", int'(bus.ext_ready), int'(mq.size() != DEPTH));
        chk("cpu_data",  int'(bus.cpu_data),  (mq.size() != 0) ? int'(mq[0]) : 0);
        chk("cpu_irq",   int'(bus.cpu_irq),   int'(m_irq));
        chk("overflow",  int'(bus.overflow),  int'(m_ovf));
    endtask

    // One clock: inputs are driven at the negedge, the model advances at the posedge, and outputs are checked at the next negedge.
    task automatic step(input bit v, input logic [7:0] d, input bit a);
        bus.ext_valid = v;
        bus.ext_data  = d;
        bus.cpu_ack   = a;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_irq(input string name, input int limit);
        int i = 0;
        while (!bus.cpu_irq && i < limit) begin
            step(1'b0, 8'h00, 1'b0);
            i++;
        end
        chk(name, int'(bus.cpu_irq), 1);
    endtask

    initial begin
        int gap, irqs;
        bus.ext_valid = 1'b0;
        bus.ext_data  = 8'h00;
        bus.cpu_ack   = 1'b0;
        @(negedge clk);

        // Reset, then idle.
        reset = 1'b0;
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        reset = 1'b1;
        chk("rst_irq", int'(bus.cpu_irq), 0);
        chk("rst_ready", int'(bus.ext_ready), 1);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_data", int'(bus.cpu_data), 8'h00);
        chk("rst_ovf", int'(bus.overflow), 0);

        // Single byte.
        step(1, 8'hA5, 0);
        chk("single_data", int'(bus.cpu_data), 8'hA5);
        chk("single_irq_n", int'(bus.cpu_irq), 0);
        step(0, 8'h00, 0);
        chk("single_irq_n1", int'(bus.cpu_irq), 1);
        step(0, 8'h00, 1);
        chk("single_pop_count", int'(bus.count), 0);
        chk("single_pop_irq", int'(bus.cpu_irq), 0);
        chk("single_pop_data", int'(bus.cpu_data), 8'h00);
        repeat (HOLD + 3) step(0, 8'h00, 0);
        chk("single_post_hold_irq", int'(bus.cpu_irq), 0);

        // Fill and overflow.
        for (int i = 1; i <= DEPTH; i++) step(1, 8'(i), 0);
        chk("fill_count", int'(bus.count), DEPTH);
        chk("fill_ready", int'(bus.ext_ready), 0);
        step(1, 8'h09, 0);
        chk("ovf_set", int'(bus.overflow), 1);
        chk("ovf_count", int'(bus.count), DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            wait_irq("fill_irq_wait", 3 * HOLD);
            chk("fill_order", int'(bus.cpu_data), i);
            step(0, 8'h00, 1);
            if (i == 1) chk("ready_after_pop", int'(bus.ext_ready), 1);
        end
        chk("drained_count", int'(bus.count), 0);

        // Wrap, with simultaneous push and pop.
        for (int i = 0; i < 5; i++) step(1, 8'hE0 + 8'(i), 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1);
        step(1, 8'h10, 0);
        for (int i = 1; i <= 5; i++) begin
            chk("wrap_order", int'(bus.cpu_data), 8'h10 + i - 1);
            step(1, 8'h10 + 8'(i), 1);
        end
        chk("wrap_count", int'(bus.count), 1);
        chk("wrap_last", int'(bus.cpu_data), 8'h15);
        step(0, 8'h00, 1);
        repeat (HOLD + 2) step(0, 8'h00, 0);

        // Holdoff gaps and interrupt count.
        reset = 1'b0;
        step(0, 8'h00, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 8'h40 + 8'(i), 0);
        irqs = 0;
        for (int k = 0; k < 3; k++) begin
            wait_irq("hold_irq_wait", 3 * HOLD);
            irqs++;
            step(0, 8'h00, 1);
            gap = 0;
            while (!bus.cpu_irq && gap < 20) begin
                step(0, 8'h00, 0);
                gap++;
            end
            if (k < 2) chk("hold_gap", gap, HOLD + 1);
        end
        chk("hold_irq_total", irqs + int'(bus.cpu_irq), 3);
        step(0, 8'h00, 1);
        chk("empty_ack_count", int'(bus.count), 0);
        chk("empty_ack_data", int'(bus.cpu_data), 8'h00);
        chk("empty_ack_irq", int'(bus.cpu_irq), 0);

        // Reset mid-operation.
        for (int i = 0; i < 4; i++) step(1, 8'h50 + 8'(i), 0);
        step(0, 8'h00, 0);
        chk("mid_irq_before", int'(bus.cpu_irq), 1);
        reset = 1'b0;
        step(1, 8'h77, 1);
        reset = 1'b1;
        chk("mid_count", int'(bus.count), 0);
        chk("mid_irq", int'(bus.cpu_irq), 0);
        chk("mid_ready", int'(bus.ext_ready), 1);
        step(1, 8'h3C, 0);
        chk("mid_push", int'(bus.cpu_data), 8'h3C);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 40);
        end
        reset = 1'b1;
        step(0, 8'h00, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/io_input_fifo.md
# io_input_fifo

Input-side staging block that sits directly upstream of the `Microprocessor` core. It accepts bytes from an external source through a valid/ready handshake and buffers them in a small FIFO. It presents the oldest byte on the core's `data_in` bus and drives the core's `interrupt` line through a small request/acknowledge state machine. The core pops one byte per acknowledge pulse.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `IRQ_THRESHOLD`, 1: occupancy (1..DEPTH) at which an interrupt is requested.
- `HOLDOFF`, 4: cycles `cpu_irq` stays low after each acknowledge (1..15).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `ext_data`  in  8  byte from external source.
- `ext_valid`  in  1  source offers `ext_data` this cycle.
- `ext_ready`  out  1  FIFO can accept a byte this cycle.
- `cpu_data`  out  8  oldest buffered byte; connects to core `data_in`.
- `cpu_irq`  out  1  interrupt request; connects to core `interrupt`.
- `cpu_ack`  in  1  one-cycle pulse from core: byte on `cpu_data` consumed.
- `count`  out  log2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a byte was offered while full.

## Operation
- Storage:
  - DEPTH×8 array.
  - Write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Registered `count`.
- Push occurs when `ext_valid && ext_ready`. `ext_ready` = (`count` != DEPTH), derived from registered state only.
- Pop occurs when `cpu_ack && count != 0`. `cpu_ack` while empty is ignored; no pointer or count change.
- Simultaneous push and pop:
  - Both pointers advance and `count` is unchanged.
  - When full, no push is possible, so `cpu_ack` pops alone.
  - When empty, no pop is possible, so the push proceeds alone.
- `cpu_data` = array[rd_ptr] when `count` != 0, else 8'h00 (first-word-fall-through). There is no combinational path from `ext_*` to `cpu_data`.
- `ext_valid` while full: the byte is dropped and `overflow` is set. `overflow` clears only on reset.
- Interrupt FSM, states IDLE, PEND, HOLD:
  - IDLE: `cpu_irq`=0. Go to PEND when `count` >= IRQ_THRESHOLD.
  - PEND: `cpu_irq`=1.
    - On `cpu_ack` (pop taken), load the holdoff counter with HOLDOFF and go to HOLD.
    - If `count` falls below threshold without an ack (not possible in normal use), go to IDLE.
  - HOLD: `cpu_irq`=0; the counter decrements each cycle. At 0, go to IDLE, which re-evaluates occupancy the same cycle it is entered.
  - `cpu_ack` in IDLE or HOLD still pops (if non-empty) but does not change FSM state.
- Reset (`reset`=0 at an edge):
  - pointers=0, `count`=0, `overflow`=0, FSM=IDLE, holdoff counter=0.
  - Outputs: `cpu_irq`=0, `ext_ready`=1, `cpu_data`=8'h00.
  - Reset mid-operation discards all buffered bytes. A push or ack in the reset cycle is ignored.

## Timing
- Push accepted at edge N:
  - `count` and `cpu_data` (if previously empty) update after edge N.
  - `cpu_irq` rises after edge N+1, so the first-byte-to-interrupt latency is 2 cycles.
- Pop at edge N: `cpu_data` shows the next byte (or 00) and `count` decrements after edge N. `cpu_irq` falls after edge N.
- HOLD lasts exactly HOLDOFF cycles. With data still pending, `cpu_irq` re-rises HOLDOFF+1 cycles after the ack edge (one cycle in IDLE).
- `ext_ready` deasserts the cycle after the DEPTH-th push and reasserts the cycle after the first pop.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Ordering is preserved across the wrap.
- Sustained throughput: 1 byte/cycle in, 1 byte/cycle out.

## Test plan
- Reset then idle: hold `reset`=0 for 2 edges, release → `cpu_irq`=0, `ext_ready`=1, `count`=0, `cpu_data`=00, `overflow`=0.
- Single byte:
  - Stimulus: push 8'hA5 at edge N.
  - Required: `cpu_data`=A5 after N; `cpu_irq`=1 after N+1.
  - Then: `cpu_ack` pulse → `count`=0, `cpu_irq`=0, `cpu_data`=00; `cpu_irq` stays 0 after HOLD ends.
- Fill and overflow:
  - Push 01..08 on consecutive cycles → `count`=8, `ext_ready`=0.
  - Offer 09 → `overflow`=1, `count` stays 8.
  - Ack 8 times, each separated by HOLDOFF+1 cycles → bytes read in order 01..08; 09 is never seen.
- Wrap and simultaneous ops:
  - Push 5 bytes, pop 5, then push 6 bytes (10..15) with `cpu_ack` asserted in the same cycles as pushes 2..6 → reads return 10..14 in order.
  - `count` ends at 1 and pointers wrap correctly.
- Holdoff:
  - Load 3 bytes with HOLDOFF=4 and ack on each `cpu_irq` rise.
  - Required: each `cpu_irq` low gap is 5 cycles and exactly 3 interrupts occur.
  - An extra `cpu_ack` issued while empty → no change.
- Reset mid-operation: with 4 bytes buffered and `cpu_irq`=1, assert `reset`=0 for one edge → all state cleared; next push of 8'h3C appears as `cpu_data`=3C.
